// File: rtl/spram_arbiter_if.sv
// rtl/spram_arbiter_if.sv - requester-side bus of the spram arbiter
// Two request ports plus the shared read-response channel.
interface spram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p1_gnt,
    input  rsp_valid, rsp_id, rsp_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p1_gnt,
    output rsp_valid, rsp_id, rsp_rdata
  );
endinterface

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - zero-fill sequencer and round-robin arbiter for one spram macro
// Sweeps the macro to zero after reset, then shares it between two requesters.
module spram_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  spram_arbiter_if.slave    bus,
  output logic              init_done,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {ST_CLEAR, ST_ARB} state_e;

  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              rr_ptr_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic              init_done_q;

  logic gnt0, gnt1;

  // rr_ptr_q == 0 favours port 0 on contention; grants are gated by reset too.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state_q == ST_ARB) begin
      if (bus.p0_req && (!bus.p1_req || !rr_ptr_q)) begin
        gnt0 = 1'b1;
      end else if (bus.p1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    ram_cen = 1'b0;
    ram_wen = 1'b0;
    ram_a   = '0;
    ram_d   = '0;
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        ram_cen = 1'b1;
        ram_wen = 1'b1;
        ram_a   = clr_cnt_q;
      end else if (gnt0) begin
        ram_cen = 1'b1;
        ram_wen = bus.p0_we;
        ram_a   = bus.p0_addr;
        ram_d   = bus.p0_wdata;
      end else if (gnt1) begin
        ram_cen = 1'b1;
        ram_wen = bus.p1_we;
        ram_a   = bus.p1_addr;
        ram_d   = bus.p1_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q     <= ST_ARB;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          if (gnt0 || gnt1) begin
            rr_ptr_q <= gnt0;
          end
          // ram_q is valid the cycle after the access, so only the tag is registered.
          rsp_valid_q <= (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);
          if ((gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we)) begin
            rsp_id_q <= gnt1;
          end
        end
      endcase
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = ram_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed self-checking bench for spram_arbiter
// Includes a behavioural model of the single-port macro behind the arbiter.
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done, ram_cen, ram_wen;
  logic [7:0]  ram_a;
  logic [31:0] ram_d;
  logic [31:0] ram_q;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  spram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  spram_arbiter #(.ADDR_W(8), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_done (init_done),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) mem[ram_a] <= ram_d;
      else         ram_q <= mem[ram_a];
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    #1;
  endtask

  task automatic req0(input logic we, input logic [7:0] a, input logic [31:0] d);
    bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    #1;
  endtask

  task automatic req1(input logic we, input logic [7:0] a, input logic [31:0] d);
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    #1;
  endtask

  task automatic do_sweep(input bit hold_p1);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (hold_p1 && i == 5) req1(1'b0, 8'h33, 32'h0);
      if (ram_cen !== 1'b1 || ram_wen !== 1'b1 || ram_a !== 8'(i) || ram_d !== 32'h0 ||
          init_done !== 1'b0 || bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin
        bad++;
      end
      step();
    end
    expect_eq("sweep_bad_cycles", bad, 0);
  endtask

  initial begin
    logic [31:0] exp4 [4];
    exp4 = '{32'h0, 32'hA1, 32'hA2, 32'h0};
    for (int i = 0; i < 256; i++) mem[i] = 32'hBAD0_0000 | i;
    rst_n = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    req0(1'b1, 8'h05, 32'h1234);
    #2;
    expect_eq("rst_p0_gnt", bus.p0_gnt, 0);
    expect_eq("rst_cen", ram_cen, 0);
    expect_eq("rst_wen", ram_wen, 0);
    expect_eq("rst_a", ram_a, 0);
    expect_eq("rst_rsp_valid", bus.rsp_valid, 0);
    expect_eq("rst_init_done", init_done, 0);
    idle();

    step(); rst_n = 1'b1; #1;
    do_sweep(1'b1);
    expect_eq("init_done_after_256", init_done, 1);
    expect_eq("held_p1_first_arb_gnt", bus.p1_gnt, 1);
    expect_eq("held_p1_a", ram_a, 8'h33);
    expect_eq("held_p1_wen", ram_wen, 0);
    step(); idle();
    expect_eq("held_p1_rsp_valid", bus.rsp_valid, 1);
    expect_eq("held_p1_rsp_id", bus.rsp_id, 1);
    expect_eq("held_p1_rdata_zeroed", bus.rsp_rdata, 32'h0);

    req0(1'b0, 8'h7F, 32'h0);
    expect_eq("rd7f_gnt", bus.p0_gnt, 1);
    step(); idle();
    expect_eq("rd7f_valid", bus.rsp_valid, 1);
    expect_eq("rd7f_id", bus.rsp_id, 0);
    expect_eq("rd7f_rdata", bus.rsp_rdata, 32'h0);

    req0(1'b1, 8'h10, 32'hDEADBEEF);
    expect_eq("wr10_p0_gnt", bus.p0_gnt, 1);
    expect_eq("wr10_wen", ram_wen, 1);
    expect_eq("wr10_d", ram_d, 32'hDEADBEEF);
    step(); idle();
    expect_eq("wr10_no_rsp", bus.rsp_valid, 0);
    req1(1'b0, 8'h10, 32'h0);
    expect_eq("rd10_p1_gnt", bus.p1_gnt, 1);
    step(); idle();
    expect_eq("rd10_valid", bus.rsp_valid, 1);
    expect_eq("rd10_id", bus.rsp_id, 1);
    expect_eq("rd10_rdata", bus.rsp_rdata, 32'hDEADBEEF);

    req0(1'b1, 8'h01, 32'hA1);
    step(); idle();
    req1(1'b1, 8'h02, 32'hA2);
    step(); idle();

    req0(1'b0, 8'h01, 32'h0);
    req1(1'b0, 8'h02, 32'h0);
    for (int k = 0; k < 6; k++) begin
      expect_eq("alt_p0_gnt", bus.p0_gnt, (k % 2 == 0) ? 1 : 0);
      expect_eq("alt_onehot", bus.p0_gnt & bus.p1_gnt, 0);
      if (k > 0) begin
        expect_eq("alt_valid", bus.rsp_valid, 1);
        expect_eq("alt_id", bus.rsp_id, ((k - 1) % 2 == 0) ? 0 : 1);
        expect_eq("alt_rdata", bus.rsp_rdata, ((k - 1) % 2 == 0) ? 32'hA1 : 32'hA2);
      end
      step();
    end
    idle();
    expect_eq("alt_last_id", bus.rsp_id, 1);
    expect_eq("alt_last_rdata", bus.rsp_rdata, 32'hA2);

    for (int k = 0; k < 4; k++) begin
      req0(1'b0, 8'(k), 32'h0);
      expect_eq("seq_p0_gnt", bus.p0_gnt, 1);
      if (k > 0) begin
        expect_eq("seq_valid", bus.rsp_valid, 1);
        expect_eq("seq_id", bus.rsp_id, 0);
        expect_eq("seq_rdata", bus.rsp_rdata, exp4[k-1]);
      end
      step();
    end
    idle();
    expect_eq("seq_last_valid", bus.rsp_valid, 1);
    expect_eq("seq_last_rdata", bus.rsp_rdata, exp4[3]);
    step();
    expect_eq("seq_idle_valid", bus.rsp_valid, 0);
    expect_eq("seq_idle_cen", ram_cen, 0);

    req0(1'b0, 8'h01, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    expect_eq("arb_rst_rsp_valid", bus.rsp_valid, 0);
    expect_eq("arb_rst_p0_gnt", bus.p0_gnt, 0);
    expect_eq("arb_rst_init_done", init_done, 0);
    expect_eq("arb_rst_cen", ram_cen, 0);
    idle();

    step(); rst_n = 1'b1; #1;
    for (int i = 0; i < 100; i++) step();
    expect_eq("mid_sweep_a", ram_a, 8'd100);
    rst_n = 1'b0;
    #1;
    expect_eq("clr_rst_cen", ram_cen, 0);
    expect_eq("clr_rst_a", ram_a, 0);
    expect_eq("clr_rst_init_done", init_done, 0);
    step(); rst_n = 1'b1; #1;
    do_sweep(1'b0);
    expect_eq("resweep_init_done", init_done, 1);
    expect_eq("resweep_mem10", mem[8'h10], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Sequencer and arbiter for one spram_256x32 single-port macro.
- After reset, sweeps all entries to zero.
- Then shares the macro between two requesters (port 0, port 1) with round-robin, one access per cycle.
- Returns read data with a requester ID one cycle after the grant.
- Sits between cache/TLB-side logic and the RAM wrapper.

Parameters:
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W.
- DATA_W, 32, RAM data width.
- CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = go straight to ARB.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- p0_req  input  1  port 0 request
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  ADDR_W  port 0 address
- p0_wdata  input  DATA_W  port 0 write data
- p0_gnt  output  1  port 0 granted this cycle (combinational)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt  same as port 0, for port 1
- rsp_valid  output  1  read data valid
- rsp_id  output  1  port that issued the returning read
- rsp_rdata  output  DATA_W  read data
- init_done  output  1  clear sweep finished; arbitration active
- ram_cen  output  1  to wrapper CEN; active-high access enable
- ram_wen  output  1  to wrapper WEN; active-high write enable
- ram_a  output  ADDR_W  to wrapper A
- ram_d  output  DATA_W  to wrapper D
- ram_q  input  DATA_W  from wrapper Q; valid the cycle after a read access

Behaviour:
- Reset values (async, rst_n=0): state=CLEAR (ARB if CLEAR_ON_RESET=0), clr_cnt=0, rr_ptr=0 (port 0 has priority), rsp_valid=0, rsp_id=0, init_done=0 (1 if CLEAR_ON_RESET=0).
- Grants are 0 during reset. ram_cen, ram_wen, ram_a and ram_d are 0 during reset.
- FSM: CLEAR -> ARB only. No other transitions except reset.
- CLEAR state:
  - Each cycle: ram_cen=1, ram_wen=1, ram_a=clr_cnt, ram_d=0; clr_cnt increments.
  - After the write at clr_cnt=2**ADDR_W-1 (cycle 256 at defaults), next state=ARB and init_done=1 from the following cycle.
  - Total 256 write cycles, no wrap.
  - p0_gnt=p1_gnt=0 throughout; requests are held off, not dropped.
- ARB state, grant selection (combinational in the same cycle as req):
  - Only p0_req -> grant p0.
  - Only p1_req -> grant p1.
  - Both -> grant the port rr_ptr selects.
  - Neither -> ram_cen=0, ram_wen=0; ram_a and ram_d hold don't-care (drive 0).
- ARB state, granted access: ram_cen=1, ram_wen=granted we, ram_a=granted addr, ram_d=granted wdata.
- rr_ptr update: on any grant, rr_ptr <= ~granted_id. No grant -> rr_ptr holds.
- Handshake:
  - Access completes in the cycle req && gnt at the rising edge.
  - A requester holds req/we/addr/wdata stable until gnt. It may drop req before gnt with no side effect.
  - At most one grant per cycle; p0_gnt && p1_gnt is never 1.
- Read response:
  - Read granted in cycle N -> rsp_valid=1 in cycle N+1, rsp_id=granted port, rsp_rdata=ram_q (combinational pass-through, not registered).
  - Writes produce no response.
  - Back-to-back reads give rsp_valid every cycle, with no bubbles and no stall.
  - Requesters are always ready for responses; there is no backpressure.
- Same-address read and write from different ports in the same cycle: only one is granted. The loser sees the winner's effect when it is granted later.
- Write then read of the same address on consecutive grants: the read returns the new data (macro is write-then-read ordered across cycles).
- Reset asserted mid-CLEAR or mid-ARB:
  - Immediate return to reset values; an in-flight read response is discarded (rsp_valid=0).
  - The sweep restarts from address 0 after rst_n deasserts.

Test Plan:
- Reset release, no requests: ram_wen=ram_cen=1 with ram_a 0..255 for exactly 256 cycles, then init_done=1. A later p0 read of addr 0x7F returns rsp_rdata=0, rsp_id=0.
- p0 write addr 0x10 data 0xDEADBEEF, then p1 read addr 0x10: p1_gnt the cycle after p0_gnt, then rsp_valid=1, rsp_id=1, rsp_rdata=0xDEADBEEF.
- p0 and p1 read addrs 0x01/0x02 continuously, preloaded with 0xA1/0xA2: grants alternate p0,p1,p0,p1 starting with p0 after reset. rsp_id alternates 0,1,… and data alternates 0xA1,0xA2, with rsp_valid high every cycle.
- p1_req held high from cycle 5 after reset (during CLEAR): p1_gnt=0 until init_done, then granted in the first ARB cycle.
- Only p0 reads addrs 0..3 on consecutive cycles: p0_gnt=1 on four consecutive cycles, and 4 consecutive rsp_valid pulses with id 0.
- rst_n pulsed low at sweep address 100: outputs return to reset values asynchronously. The sweep restarts at ram_a=0, and init_done asserts 256 cycles after release.
